// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the baud divider calculation.
// Intended for reuse by both the receiver and the future transmitter.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_t;

   // Clocks per oversampling tick, rounded to nearest.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, restartable so the
// sampling phase locks to the detected start edge.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_too_small
      $error("uart_baud_tick: DIV must be at least 2");
   end

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (restart || cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with 3-sample majority vote, false-start rejection,
// parity/framing/overrun flags and a valid/ready output register.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] IDX_S0    = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] IDX_S1    = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] IDX_VOTE  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] IDX_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_DONE = BW'(DATA_BITS);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_os: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_os: STOP_BITS must be 1 or 2");
   end

   rx_state_t            state, state_next;
   logic [1:0]           sync;
   logic                 rx_s;
   logic                 armed;
   logic                 restart;
   logic                 tick;
   logic [TW-1:0]        tick_idx;
   logic [BW-1:0]        bit_cnt;
   logic [1:0]           samp;
   logic                 vote;
   logic                 at_vote;
   logic                 bit_end;
   logic                 complete;
   logic                 done;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic                 stop_bad;
   logic                 par_red;
   logic                 parity_calc;
   logic                 accept;

   uart_baud_tick #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .tick    (tick)
   );

   assign rx_s    = sync[1];
   assign vote    = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
   assign at_vote = tick && (tick_idx == IDX_VOTE);
   assign bit_end = tick && (tick_idx == IDX_LAST);
   assign busy    = (state != ST_IDLE);
   assign accept  = data_valid && data_ready;
   assign par_red = ^{shift, par_bit};

   always_comb begin
      parity_calc = 1'b0;
      if (PARITY == PARITY_ODD) begin
         parity_calc = ~par_red;
      end else if (PARITY == PARITY_EVEN) begin
         parity_calc = par_red;
      end
   end

   // The frame completes at the last stop vote rather than bit end, so a following
   // start edge right after the stop bit is still caught.
   always_comb begin
      state_next = state;
      restart    = 1'b0;
      complete   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_s && armed) begin
               state_next = ST_START;
               restart    = 1'b1;
            end
         end
         ST_START: begin
            if (at_vote && vote) begin
               state_next = ST_IDLE;
            end else if (bit_end) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end && bit_cnt == DATA_DONE) begin
               state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (at_vote && bit_cnt == STOP_LAST) begin
               complete   = 1'b1;
               state_next = (stop_bad || !vote) ? ST_WAIT_IDLE : ST_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (rx_s) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         sync     <= 2'b11;
         armed    <= 1'b0;
         tick_idx <= '0;
         bit_cnt  <= '0;
         samp     <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         stop_bad <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_next;
         sync  <= {sync[0], rx};
         done  <= complete;
         if (restart) begin
            armed <= 1'b0;
         end else if (rx_s) begin
            armed <= 1'b1;
         end
         if (restart) begin
            tick_idx <= '0;
         end else if (tick) begin
            tick_idx <= (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
         end
         if (tick && tick_idx == IDX_S0) begin
            samp[0] <= rx_s;
         end
         if (tick && tick_idx == IDX_S1) begin
            samp[1] <= rx_s;
         end
         if (restart) begin
            bit_cnt <= '0;
         end else if (state == ST_DATA && bit_end && bit_cnt == DATA_DONE) begin
            bit_cnt <= '0;
         end else if (at_vote && (state == ST_DATA || state == ST_STOP)) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (at_vote && state == ST_DATA) begin
            shift <= {vote, shift[DATA_BITS-1:1]};
         end
         if (at_vote && state == ST_PARITY) begin
            par_bit <= vote;
         end
         if (restart) begin
            stop_bad <= 1'b0;
         end else if (at_vote && state == ST_STOP) begin
            stop_bad <= stop_bad | ~vote;
         end
      end
   end

   // A new word overwrites an unaccepted one; an accept in the same cycle still counts as consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else if (done) begin
         data_out    <= shift;
         parity_err  <= parity_calc;
         frame_err   <= stop_bad;
         data_valid  <= 1'b1;
         overrun_err <= data_valid && !data_ready;
      end else if (accept) begin
         data_valid  <= 1'b0;
         overrun_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: three receiver instances (8N1, 8E1, 8N2) driven by a frame generator,
// with accepted words captured by a monitor and compared against an expected-word queue.
module tb_uart_rx_os;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 10_000;
   localparam int OS       = 16;
   localparam int BIT_CLK  = 160;
   localparam int NDUT     = 3;
   localparam int PAR_DUT  = 1;
   localparam int STOP2_DUT = 2;

   typedef struct packed {
      logic [1:0] dut;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       ovr;
   } obs_t;

   typedef struct {
      int         d;
      logic [7:0] data;
      logic       par;
      logic       s1;
      logic       s2;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx     [NDUT];
   logic       ready  [NDUT];
   logic [7:0] dout   [NDUT];
   logic       dvalid [NDUT];
   logic       perr   [NDUT];
   logic       ferr   [NDUT];
   logic       ovr    [NDUT];
   logic       busy   [NDUT];

   obs_t got [128];
   int   got_cnt = 0;
   int   rd_ptr  = 0;
   obs_t exp_q [$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs [11];

   always #5 clk = ~clk;

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .reset_n(reset_n), .rx(rx[0]), .data_out(dout[0]), .data_valid(dvalid[0]), .data_ready(ready[0]),
      .parity_err(perr[0]), .frame_err(ferr[0]), .overrun_err(ovr[0]), .busy(busy[0]));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .reset_n(reset_n), .rx(rx[1]), .data_out(dout[1]), .data_valid(dvalid[1]), .data_ready(ready[1]),
      .parity_err(perr[1]), .frame_err(ferr[1]), .overrun_err(ovr[1]), .busy(busy[1]));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .reset_n(reset_n), .rx(rx[2]), .data_out(dout[2]), .data_valid(dvalid[2]), .data_ready(ready[2]),
      .parity_err(perr[2]), .frame_err(ferr[2]), .overrun_err(ovr[2]), .busy(busy[2]));

   // Capture every accepted word, sampled on the falling edge.
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (reset_n && dvalid[d] && ready[d]) begin
            got[got_cnt % 128] = '{dut: 2'(d), data: dout[d], perr: perr[d], ferr: ferr[d], ovr: ovr[d]};
            got_cnt++;
         end
      end
   end

   initial begin
      #900_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic send_bit(input int d, input logic b, input bit glitch);
      if (!glitch) begin
         rx[d] = b;
         repeat (BIT_CLK) @(posedge clk);
         #1;
      end else begin
         rx[d] = 1'b1;
         repeat (66) @(posedge clk);
         #1 rx[d] = 1'b0;
         repeat (16) @(posedge clk);
         #1 rx[d] = 1'b1;
         repeat (BIT_CLK - 82) @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input int d, input logic [7:0] data, input logic par, input logic s1,
                                 input logic s2, input int glitch_bit, input logic idle);
      @(posedge clk);
      #1;
      send_bit(d, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(d, data[i], i == glitch_bit);
      end
      if (d == PAR_DUT) send_bit(d, par, 1'b0);
      send_bit(d, s1, 1'b0);
      if (d == STOP2_DUT) send_bit(d, s2, 1'b0);
      rx[d] = idle;
   endtask

   task automatic drain(input string name);
      obs_t g;
      obs_t e;
      int   waited = 0;
      while (got_cnt <= rd_ptr && waited < 600) begin
         @(posedge clk);
         #2;
         waited++;
      end
      if (got_cnt <= rd_ptr) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL %s: no word accepted within 600 cycles", name);
      end else if (exp_q.size() == 0) begin
         g = got[rd_ptr % 128];
         rd_ptr++;
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL %s: unexpected word 0x%0h, expected none", name, g);
      end else begin
         g = got[rd_ptr % 128];
         rd_ptr++;
         e = exp_q.pop_front();
         check_output(name, 32'(g), 32'(e));
      end
   endtask

   initial begin
      vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{2, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{2, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{2, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      reset_n = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         rx[d]    = 1'b1;
         ready[d] = 1'b1;
      end
      repeat (5) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check_output($sformatf("reset_outputs_%0d", d),
                      32'({dout[d], dvalid[d], perr[d], ferr[d], ovr[d], busy[d]}), 32'h0);
      end
      reset_n = 1'b1;
      repeat (5) @(posedge clk);

      // Vector table across all three frame formats.
      for (int v = 0; v < 11; v++) begin
         exp_q.push_back('{dut: 2'(vecs[v].d), data: vecs[v].data, perr: vecs[v].exp_perr,
                           ferr: vecs[v].exp_ferr, ovr: 1'b0});
         apply_stimulus(vecs[v].d, vecs[v].data, vecs[v].par, vecs[v].s1, vecs[v].s2, -1, 1'b1);
         repeat (20) @(posedge clk);
         drain($sformatf("vec_%0d", v));
      end

      // False start: 60 clocks low is rejected, then a real frame follows.
      @(posedge clk);
      #1 rx[0] = 1'b0;
      repeat (30) @(posedge clk);
      #1 check_output("false_start_busy_hi", 32'(busy[0]), 32'h1);
      repeat (30) @(posedge clk);
      #1 rx[0] = 1'b1;
      repeat (80) @(posedge clk);
      #1 check_output("false_start_busy_lo", 32'(busy[0]), 32'h0);
      check_output("false_start_no_word", 32'(got_cnt), 32'(rd_ptr));
      exp_q.push_back('{dut: 2'd0, data: 8'h3C, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
      apply_stimulus(0, 8'h3C, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      repeat (20) @(posedge clk);
      drain("after_false_start");

      // Bad second stop bit with the line held low: receiver waits for idle.
      exp_q.push_back('{dut: 2'd2, data: 8'h33, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
      apply_stimulus(2, 8'h33, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      drain("stop2_low");
      repeat (400) @(posedge clk);
      #1 check_output("wait_idle_busy", 32'(busy[2]), 32'h1);
      check_output("wait_idle_no_word", 32'(got_cnt), 32'(rd_ptr));
      rx[2] = 1'b1;
      repeat (10) @(posedge clk);
      #1 check_output("wait_idle_exit", 32'(busy[2]), 32'h0);
      exp_q.push_back('{dut: 2'd2, data: 8'h55, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
      apply_stimulus(2, 8'h55, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      repeat (20) @(posedge clk);
      drain("after_wait_idle");

      // Overrun: two words with no accept, the second overwrites the first.
      ready[0] = 1'b0;
      apply_stimulus(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      repeat (20) @(posedge clk);
      #1 check_output("hold_first", 32'({dvalid[0], dout[0], ovr[0]}), 32'({1'b1, 8'h11, 1'b0}));
      apply_stimulus(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      repeat (20) @(posedge clk);
      #1 check_output("overrun_state", 32'({dvalid[0], dout[0], ovr[0]}), 32'({1'b1, 8'h22, 1'b1}));
      exp_q.push_back('{dut: 2'd0, data: 8'h22, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
      ready[0] = 1'b1;
      drain("overrun_word");
      check_output("overrun_cleared", 32'({dvalid[0], ovr[0]}), 32'h0);

      // Short low glitch inside a 1 bit is outvoted.
      exp_q.push_back('{dut: 2'd0, data: 8'hFF, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
      apply_stimulus(0, 8'hFF, 1'b0, 1'b1, 1'b1, 3, 1'b1);
      repeat (20) @(posedge clk);
      drain("glitch");

      // Reset in the middle of a data bit drops the frame and the held word.
      ready[0] = 1'b0;
      apply_stimulus(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      repeat (20) @(posedge clk);
      #1 check_output("held_before_reset", 32'({dvalid[0], dout[0]}), 32'({1'b1, 8'h5A}));
      @(posedge clk);
      #1;
      send_bit(0, 1'b0, 1'b0);
      send_bit(0, 1'b1, 1'b0);
      rx[0] = 1'b0;
      repeat (40) @(posedge clk);
      #1 check_output("busy_mid_data", 32'(busy[0]), 32'h1);
      reset_n = 1'b0;
      rx[0]   = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_output("reset_mid_frame",
                      32'({dout[0], dvalid[0], perr[0], ferr[0], ovr[0], busy[0]}), 32'h0);
      reset_n  = 1'b1;
      ready[0] = 1'b1;
      repeat (2000) @(posedge clk);
      #1 check_output("no_word_after_reset", 32'(dvalid[0]), 32'h0);

      check_output("all_expected_seen", 32'(exp_q.size()), 32'h0);
      check_output("no_extra_words", 32'(got_cnt), 32'(rd_ptr));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
